// File: rtl/io_bus_responder_pkg.sv
// Shared constants for the IO bus responder: window base, register offsets,
// access-size encodings, reset values, the 7-segment table and a byte-merge helper.
package io_bus_responder_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_F000;

  localparam logic [11:0] OFS_SEG   = 12'h000;
  localparam logic [11:0] OFS_TIMER = 12'h020;
  localparam logic [11:0] OFS_LED   = 12'h060;
  localparam logic [11:0] OFS_SW    = 12'h070;
  localparam logic [11:0] OFS_BTN   = 12'h078;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [31:0] SEG_RST   = 32'h0000_0000;
  localparam logic [23:0] LED_RST   = 24'h00_0000;
  localparam logic [31:0] TIMER_RST = 32'h0000_0000;

  // Active-low {dp,g..a}; dp is always off.
  function automatic logic [7:0] hex7(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
      4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
      4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
      4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/io_bus_responder_if.sv
// CPU-to-responder IO bus. The master presents one access per cycle (no
// handshake); rd returns the word for the previous cycle's address.
interface io_bus_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] wd;
  logic              we;
  logic [DATA_W-1:0] rd;

  modport master (output addr, ctrl, wd, we, input rd);
  modport slave  (input addr, ctrl, wd, we, output rd);
endinterface

// File: rtl/io_bus_responder_seg7_scan.sv
// 8-digit multiplexed 7-segment driver: SCAN_DIV clocks per digit slot,
// digit index wraps 7->0.
module seg7_scan
  import io_bus_responder_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cx
);
  logic [15:0] cnt;
  logic [2:0]  idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == SCAN_DIV - 16'd1) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign seg_an = ~(8'b0000_0001 << idx);
  assign seg_cx = hex7(value[{idx, 2'b00} +: 4]);

endmodule

// File: rtl/io_bus_responder.sv
// IO bus responder: RAM port / peripheral decode, LED/SEG/SW/BTN registers,
// 1-cycle read return. Optional TIMER register under IO_BUS_RESPONDER_TIMER_EN.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          CTRL_W   = 2,
  parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  io_bus_responder_if.slave  bus,
  output logic [ADDR_W-3:0]  dram_addr,
  output logic [DATA_W-1:0]  dram_wd,
  output logic [3:0]         dram_be,
  input  logic [DATA_W-1:0]  dram_rd,
  output logic [23:0]        led,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_cx,
  output logic               misalign
);
  logic [1:0]  ofs;
  logic [9:0]  wi;
  logic        io_sel, legal, io_wr;
  logic [3:0]  be_raw, be;
  logic [31:0] wd_sh, io_rd, led_merged;

  logic [31:0] seg_q, io_rd_q;
  logic [23:0] led_q, sw_s1, sw_s2;
  logic [4:0]  btn_s1, btn_s2;
  logic        io_sel_q, misalign_q, live_q;

  assign ofs    = bus.addr[1:0];
  assign wi     = bus.addr[11:2];
  assign io_sel = (bus.addr[ADDR_W-1:12] == IO_BASE[31:12]);
  assign wd_sh  = bus.wd << {ofs, 3'b000};

  always_comb begin
    be_raw = 4'b1111;
    legal  = (ofs == 2'b00);
    case (size_e'(bus.ctrl))
      SZ_BYTE: begin be_raw = 4'b0001 << ofs; legal = 1'b1;    end
      SZ_HALF: begin be_raw = 4'b0011 << ofs; legal = ~ofs[0]; end
      default: ;
    endcase
  end

  assign be    = legal ? be_raw : 4'b0000;
  assign io_wr = bus.we & legal & io_sel;

  // RAM writes are suppressed in the reset cycle, same as register writes.
  assign dram_addr = bus.addr[ADDR_W-1:2];
  assign dram_wd   = wd_sh;
  assign dram_be   = (bus.we & ~io_sel & ~rst) ? be : 4'b0000;

  assign led_merged = merge_bytes({8'h00, led_q}, wd_sh, be);

`ifdef IO_BUS_RESPONDER_TIMER_EN
  logic [31:0] timer_q;
  always_ff @(posedge clk) begin
    if (rst)
      timer_q <= TIMER_RST;
    else if (io_wr && wi == OFS_TIMER[11:2])
      timer_q <= merge_bytes(timer_q, wd_sh, be);
    else
      timer_q <= timer_q + 32'd1;
  end
`endif

  always_comb begin
    io_rd = 32'h0;
    case (wi)
      OFS_SEG[11:2]:   io_rd = seg_q;
      OFS_LED[11:2]:   io_rd = {8'h00, led_q};
      OFS_SW[11:2]:    io_rd = {8'h00, sw_s2};
      OFS_BTN[11:2]:   io_rd = {27'h0, btn_s2};
`ifdef IO_BUS_RESPONDER_TIMER_EN
      OFS_TIMER[11:2]: io_rd = timer_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= SEG_RST;
      led_q      <= LED_RST;
      io_rd_q    <= 32'h0;
      io_sel_q   <= 1'b0;
      misalign_q <= 1'b0;
      live_q     <= 1'b0;
      sw_s1      <= '0;
      sw_s2      <= '0;
      btn_s1     <= '0;
      btn_s2     <= '0;
    end else begin
      if (io_wr && wi == OFS_SEG[11:2]) seg_q <= merge_bytes(seg_q, wd_sh, be);
      if (io_wr && wi == OFS_LED[11:2]) led_q <= led_merged[23:0];
      io_rd_q    <= io_rd;
      io_sel_q   <= io_sel;
      misalign_q <= bus.we & ~legal;
      live_q     <= 1'b1;
      sw_s1      <= sw;
      sw_s2      <= sw_s1;
      btn_s1     <= btn;
      btn_s2     <= btn_s1;
    end
  end

  // live_q keeps the first read after reset at zero regardless of dram_rd.
  assign bus.rd   = !live_q ? '0 : (io_sel_q ? io_rd_q : dram_rd);
  assign led      = led_q;
  assign misalign = misalign_q;

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .value  (seg_q),
    .seg_an (seg_an),
    .seg_cx (seg_cx)
  );

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: read results go through an expected
// queue checked by a negedge monitor; side outputs are checked inline.
module tb_io_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] dram_addr;
  logic [31:0] dram_wd, dram_rd;
  logic [3:0]  dram_be;
  logic [23:0] led, sw;
  logic [4:0]  btn;
  logic [7:0]  seg_an, seg_cx;
  logic        misalign;

  logic        rd_req = 1'b0;
  logic        rd_valid = 1'b0;
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  io_bus_responder_if #(.ADDR_W(32), .DATA_W(32), .CTRL_W(2)) bus_if ();

  io_bus_responder #(.SCAN_DIV(16'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .dram_addr (dram_addr),
    .dram_wd   (dram_wd),
    .dram_be   (dram_be),
    .dram_rd   (dram_rd),
    .led       (led),
    .sw        (sw),
    .btn       (btn),
    .seg_an    (seg_an),
    .seg_cx    (seg_cx),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_valid <= rd_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read monitor: the word for last cycle's read is on bus_rd now.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_unexpected", bus_if.rd, 32'hxxxx_xxxx);
        else check("bus_rd", bus_if.rd, exp_q.pop_front());
      end
    end
  end

  task automatic set_bus(input logic [31:0] a, input logic [1:0] c, input logic [31:0] wd,
                         input logic we, input logic rd, input logic [31:0] exp);
    bus_if.addr = a;
    bus_if.ctrl = c;
    bus_if.wd   = wd;
    bus_if.we   = we;
    rd_req      = rd;
    if (rd) exp_q.push_back(exp);
  endtask

  task automatic idle();
    set_bus(32'h0, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  exp_cx [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [15:0] hi16;

  initial begin
    rst = 1'b1; sw = 24'hABCDEF; btn = 5'h15; dram_rd = 32'hDEAD_BEEF;
    idle();
    step();
    // write + read during reset: write dropped, read returns 0
    set_bus(32'hFFFF_F060, 2'b10, 32'h00FF_FFFF, 1'b1, 1'b1, 32'h0);
    step();
    rst = 1'b0;
    set_bus(32'hFFFF_F000, 2'b10, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("rst_seg_an", {24'h0, seg_an}, 32'hFE);
    check("rst_seg_cx", {24'h0, seg_cx}, 32'hC0);
    check("rst_led", {8'h0, led}, 32'h0);
    check("rst_bus_rd", bus_if.rd, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    step();
    idle();
    @(negedge clk);
    check("scan_an_0", {24'h0, seg_an}, 32'hFE);
    check("scan_cx_0", {24'h0, seg_cx}, 32'h80);
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] an_e;
      repeat (4) @(posedge clk);
      @(negedge clk);
      an_e = 8'b0000_0001 << (k % 8);
      an_e = ~an_e;
      check("scan_an", {24'h0, seg_an}, {24'h0, an_e});
      check("scan_cx", {24'h0, seg_cx}, {24'h0, exp_cx[k % 8]});
    end
    step();

    // LED byte write, then read back
    set_bus(32'hFFFF_F061, 2'b00, 32'h5A, 1'b1, 1'b0, 32'h0);
    #1 check("io_wr_no_dram_be", {28'h0, dram_be}, 32'h0);
    step();
    check("led_byte", {8'h0, led}, 32'h0000_5A00);
    set_bus(32'hFFFF_F060, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0000_5A00);
    step();
    // read-during-write returns old value
    set_bus(32'hFFFF_F060, 2'b10, 32'h0012_3456, 1'b1, 1'b1, 32'h0000_5A00);
    step();
    check("led_word", {8'h0, led}, 32'h0012_3456);
    set_bus(32'hFFFF_F060, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0012_3456);
    step();

    // RAM half store
    set_bus(32'h0000_0102, 2'b01, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0);
    #1;
    hi16 = dram_wd[31:16];
    check("ram_half_addr", {2'b0, dram_addr}, 32'h40);
    check("ram_half_be", {28'h0, dram_be}, 32'hC);
    check("ram_half_wd", {16'h0, hi16}, 32'hBEEF);
    check("misalign_before", {31'h0, misalign}, 32'h0);
    step();

    // misaligned word write
    set_bus(32'h0000_0101, 2'b10, 32'h1122_3344, 1'b1, 1'b0, 32'h0);
    #1 check("misalign_be", {28'h0, dram_be}, 32'h0);
    step();
    check("misalign_pulse", {31'h0, misalign}, 32'h1);
    idle();
    step();
    check("misalign_clear", {31'h0, misalign}, 32'h0);

    // RAM read, switch/button reads
    set_bus(32'h0000_0200, 2'b10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    set_bus(32'hFFFF_F070, 2'b10, 32'h0, 1'b0, 1'b1, 32'h00AB_CDEF);
    step();
    set_bus(32'hFFFF_F078, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0000_0015);
    step();

    // SEG read, byte update of top byte
    set_bus(32'hFFFF_F000, 2'b10, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    step();
    set_bus(32'hFFFF_F003, 2'b00, 32'hAB, 1'b1, 1'b0, 32'h0);
    step();
    set_bus(32'hFFFF_F000, 2'b10, 32'h0, 1'b0, 1'b1, 32'hAB34_5678);
    step();

    // unmapped offset and TIMER offset
    set_bus(32'hFFFF_F040, 2'b10, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    step();
    set_bus(32'hFFFF_F040, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0);
    step();
`ifdef IO_BUS_RESPONDER_TIMER_EN
    set_bus(32'hFFFF_F020, 2'b10, 32'd100, 1'b1, 1'b0, 32'h0);
    step();
    set_bus(32'hFFFF_F020, 2'b10, 32'h0, 1'b0, 1'b1, 32'd100);
    step();
`else
    set_bus(32'hFFFF_F020, 2'b10, 32'h55, 1'b1, 1'b0, 32'h0);
    step();
    set_bus(32'hFFFF_F020, 2'b10, 32'h0, 1'b0, 1'b1, 32'h0);
    step();
`endif

    // LED half write at ofs 2, then suppressed misaligned half
    set_bus(32'hFFFF_F062, 2'b01, 32'h0000_00CC, 1'b1, 1'b0, 32'h0);
    step();
    set_bus(32'hFFFF_F061, 2'b01, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0);
    step();
    check("io_misalign_pulse", {31'h0, misalign}, 32'h1);
    set_bus(32'hFFFF_F060, 2'b10, 32'h0, 1'b0, 1'b1, 32'h00CC_3456);
    step();

    // reserved size acts as word; byte at ofs 3
    set_bus(32'h0000_0300, 2'b11, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    #1;
    check("rsvd_be", {28'h0, dram_be}, 32'hF);
    check("rsvd_wd", dram_wd, 32'hCAFE_F00D);
    step();
    set_bus(32'h0000_0207, 2'b00, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
    #1;
    check("byte3_be", {28'h0, dram_be}, 32'h8);
    check("byte3_wd", dram_wd, 32'h7700_0000);
    step();

    idle();
    step();
    step();
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
